// File: rtl/rect_fill_sequencer.sv
// rect_fill_sequencer: walks a rectangle row-major and issues one RGB444 framebuffer write per pixel.
// Optional RECT_OUTLINE_EN adds cmd_outline, which restricts writes to the rectangle border.
module rect_fill_sequencer #(
    parameter int H_STRIDE = 800,
    parameter int H_MAX    = 799,
    parameter int V_MAX    = 524,
    parameter int ADDR_W   = 19,
    parameter int COORD_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [COORD_W-1:0] cmd_x0,
    input  logic [COORD_W-1:0] cmd_y0,
    input  logic [COORD_W-1:0] cmd_x1,
    input  logic [COORD_W-1:0] cmd_y1,
    input  logic [2:0]         cmd_color,
`ifdef RECT_OUTLINE_EN
    input  logic               cmd_outline,
`endif
    input  logic               abort,
    output logic               wr_en,
    input  logic               wr_ready,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [11:0]        wr_data,
    output logic               busy,
    output logic               done,
    output logic               cmd_err
);
    typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;
    state_t state, state_n;
    logic [COORD_W-1:0] x0, y0, x1, y1, cx, cy, x0_n, y0_n, x1_n, y1_n, cx_n, cy_n, nx, ny;
    logic [ADDR_W-1:0] row_base, row_n, nrow, addr_n;
    logic [11:0] data_n;
    logic wr_en_n, done_n, err_n, accept, bad, row_end, skip, outline;

`ifdef RECT_OUTLINE_EN
    logic outline_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) outline_q <= 1'b0;
        else if (accept && !bad) outline_q <= cmd_outline;
    assign outline = outline_q;
`else
    assign outline = 1'b0;
`endif

    assign accept  = cmd_valid && cmd_ready;
    assign bad     = cmd_x0 > cmd_x1 || cmd_y0 > cmd_y1 ||
                     cmd_x1 > COORD_W'(H_MAX) || cmd_y1 > COORD_W'(V_MAX);
    assign row_end = cx == x1;
    // On interior rows of an outline only the two side pixels exist, so x0 is followed by x1.
    assign skip    = outline && cy != y0 && cy != y1 && cx == x0;
    assign nx      = row_end ? x0 : skip ? x1 : cx + COORD_W'(1);
    assign ny      = row_end ? cy + COORD_W'(1) : cy;
    assign nrow    = row_end ? row_base + ADDR_W'(H_STRIDE) : row_base;

    always_comb begin
        state_n = state;
        {x0_n, y0_n, x1_n, y1_n, cx_n, cy_n} = {x0, y0, x1, y1, cx, cy};
        row_n   = row_base;
        addr_n  = wr_addr;
        data_n  = wr_data;
        wr_en_n = wr_en;
        done_n  = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: if (accept) begin
                err_n = bad;
                if (!bad) begin
                    {x0_n, y0_n, x1_n, y1_n} = {cmd_x0, cmd_y0, cmd_x1, cmd_y1};
                    data_n  = cmd_color == 3'd1 ? 12'hF00 : cmd_color == 3'd2 ? 12'h0F0 :
                              cmd_color == 3'd3 ? 12'h00F : cmd_color == 3'd4 ? 12'hFFF : 12'h000;
                    state_n = SETUP;
                end
            end
            SETUP: if (abort) state_n = IDLE;
            else begin
                row_n   = ADDR_W'(y0) * ADDR_W'(H_STRIDE);
                cx_n    = x0;
                cy_n    = y0;
                addr_n  = ADDR_W'(y0) * ADDR_W'(H_STRIDE) + ADDR_W'(x0);
                wr_en_n = 1'b1;
                state_n = FILL;
            end
            FILL: if (abort) begin
                wr_en_n = 1'b0;
                state_n = IDLE;
            end else if (wr_en && wr_ready) begin
                if (row_end && cy == y1) begin
                    wr_en_n = 1'b0;
                    done_n  = 1'b1;
                    state_n = DONE;
                end else begin
                    cx_n   = nx;
                    cy_n   = ny;
                    row_n  = nrow;
                    addr_n = nrow + ADDR_W'(nx);
                end
            end
            DONE: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cmd_err   <= 1'b0;
            {x0, y0, x1, y1, cx, cy} <= '0;
            row_base  <= '0;
        end else begin
            state     <= state_n;
            cmd_ready <= state_n == IDLE;
            wr_en     <= wr_en_n;
            wr_addr   <= addr_n;
            wr_data   <= data_n;
            busy      <= state_n == SETUP || state_n == FILL;
            done      <= done_n;
            cmd_err   <= err_n;
            {x0, y0, x1, y1, cx, cy} <= {x0_n, y0_n, x1_n, y1_n, cx_n, cy_n};
            row_base  <= row_n;
        end
endmodule

// File: tb/tb_rect_fill_sequencer.sv
// tb_rect_fill_sequencer: scoreboard bench; a pixel-list model feeds a queue that a negedge monitor drains.
module tb_rect_fill_sequencer;
    logic clk = 0, rst_n = 0, cmd_valid = 0, abort = 0, wr_ready = 0;
    logic [15:0] cmd_x0 = 0, cmd_y0 = 0, cmd_x1 = 0, cmd_y1 = 0;
    logic [2:0] cmd_color = 0;
`ifdef RECT_OUTLINE_EN
    logic cmd_outline = 0;
`endif
    logic cmd_ready, wr_en, busy, done, cmd_err;
    logic [18:0] wr_addr;
    logic [11:0] wr_data;

    int total = 0, bad = 0, exp_done = 0, exp_err = 0, acc_cnt = 0, rdy_mode = 0;
    logic [30:0] exp_px[$];
    logic [11:0] lut[8] = '{12'h000, 12'hF00, 12'h0F0, 12'h00F, 12'hFFF, 12'h000, 12'h000, 12'h000};

    rect_fill_sequencer dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1), .cmd_color(cmd_color),
`ifdef RECT_OUTLINE_EN
        .cmd_outline(cmd_outline),
`endif
        .abort(abort), .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic fail(input string name, input logic [31:0] act);
        total++;
        bad++;
        $display("FAIL %s: got %0h expected none at %0t", name, act, $time);
    endtask

    initial forever begin
        @(posedge clk);
        #2;
        wr_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ~wr_ready : ($urandom_range(0, 3) != 0);
    end

    initial begin
        logic held;
        logic [18:0] ha;
        logic [11:0] hd;
        logic [30:0] e;
        held = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) held = 0;
            else begin
                if (held && wr_en) begin
                    check("hold_addr", wr_addr, ha);
                    check("hold_data", wr_data, hd);
                end
                held = wr_en && !wr_ready;
                ha = wr_addr;
                hd = wr_data;
                if (wr_en && wr_ready) begin
                    acc_cnt++;
                    if (exp_px.size() == 0) fail("extra_write", wr_addr);
                    else begin
                        e = exp_px.pop_front();
                        check("wr_addr", wr_addr, e[30:12]);
                        check("wr_data", wr_data, e[11:0]);
                    end
                end
                if (done) begin
                    if (exp_done == 0) fail("spurious_done", 1);
                    else begin
                        exp_done--;
                        check("done_all_written", exp_px.size(), 0);
                    end
                end
                if (cmd_err) begin
                    if (exp_err == 0) fail("spurious_cmd_err", 1);
                    else exp_err--;
                end
            end
        end
    end

    // ab > 0: abort after ab accepted writes; ab < 0: async reset after -ab writes.
    task automatic send(input int x0, input int y0, input int x1, input int y1, input int c,
                        input bit ol, input int m, input int ab, input bit tp);
        int n, cnt, npx, base, lim;
        bit bad_c;
`ifndef RECT_OUTLINE_EN
        ol = 0;
`endif
        rdy_mode = m;
        @(posedge clk);
        #1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_x0 = 16'(x0);
        cmd_y0 = 16'(y0);
        cmd_x1 = 16'(x1);
        cmd_y1 = 16'(y1);
        cmd_color = 3'(c);
`ifdef RECT_OUTLINE_EN
        cmd_outline = ol;
`endif
        cmd_valid = 1;
        bad_c = x0 > x1 || y0 > y1 || x1 > 799 || y1 > 524;
        npx = 0;
        if (bad_c) exp_err++;
        else begin
            for (int y = y0; y <= y1; y++)
                for (int x = x0; x <= x1; x++)
                    if (!ol || x == x0 || x == x1 || y == y0 || y == y1) begin
                        exp_px.push_back({19'(y * 800 + x), lut[c]});
                        npx++;
                    end
            if (ab == 0) exp_done++;
        end
        base = acc_cnt;
        @(posedge clk);
        #1;
        cmd_valid = 0;
        if (ab != 0) begin
            lim = ab > 0 ? ab : -ab;
            n = 0;
            while (acc_cnt < base + lim && n < 5000) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("accepts_reached", n < 5000, 1);
            if (ab > 0) begin
                abort = 1;
                @(posedge clk);
                #1;
                abort = 0;
                check("abort_wr_en", wr_en, 0);
                check("abort_busy", busy, 0);
                exp_px.delete();
            end else begin
                #1;
                rst_n = 0;
                #1;
                check("rst_wr_en", wr_en, 0);
                check("rst_busy", busy, 0);
                check("rst_ready", cmd_ready, 1);
                check("rst_addr", wr_addr, 0);
                exp_px.delete();
                @(negedge clk);
                #2;
                rst_n = 1;
            end
            repeat (3) @(posedge clk);
            #1;
            check("after_stop_ready", cmd_ready, 1);
            return;
        end
        if (tp) begin
            n = 0;
            while (!wr_en && n < 10) begin
                @(negedge clk);
                n++;
            end
            cnt = 0;
            while (wr_en && cnt < npx + 5) begin
                cnt++;
                @(negedge clk);
            end
            check("burst_len", cnt, npx);
        end
        n = 0;
        while (!(done || cmd_err) && n < 4 * npx + 50) begin
            @(negedge clk);
            n++;
        end
        check("finish_in_time", done || cmd_err, 1);
        @(posedge clk);
        #1;
        check("idle_ready", cmd_ready, 1);
        check("idle_busy", busy, 0);
        check("idle_wr_en", wr_en, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cmd_err", cmd_err, 0);
        @(negedge clk);
        rst_n = 1;
        send(144, 35, 144, 35, 1, 0, 0, 0, 1);
        send(144, 35, 146, 36, 3, 0, 0, 0, 1);
        send(144, 35, 146, 36, 3, 0, 1, 0, 0);
        send(200, 35, 100, 40, 2, 0, 0, 0, 0);
        send(10, 10, 20, 525, 2, 0, 0, 0, 0);
        send(0, 0, 799, 524, 4, 0, 0, 1000, 0);
        send(5, 5, 8, 7, 2, 0, 0, 0, 1);
        send(0, 0, 3, 2, 1, 1, 0, 0, 1);
        send(0, 0, 799, 524, 1, 0, 2, -300, 0);
        send(798, 523, 799, 524, 4, 0, 0, 0, 1);
        repeat (40) begin
            int x0, y0, x1, y1, r;
            x0 = int'($urandom_range(0, 799));
            y0 = int'($urandom_range(0, 524));
            x1 = x0 + int'($urandom_range(0, 11));
            y1 = y0 + int'($urandom_range(0, 5));
            if (x1 > 799) x1 = 799;
            if (y1 > 524) y1 = 524;
            r = int'($urandom_range(0, 9));
            if (r == 0) x1 = 800;
            if (r == 1) y1 = y0 > 0 ? y0 - 1 : 525;
            send(x0, y0, x1, y1, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 2)), 0, 0);
        end
        repeat (5) @(posedge clk);
        check("queue_empty", exp_px.size(), 0);
        check("dones_seen", exp_done, 0);
        check("errs_seen", exp_err, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
